axi_rd_arbiter: RTL and testbench

- Two-master, one-slave AXI-lite read-channel arbiter (AR + R only).
- Shares one instruction/data memory read port between IFU (master 0) and LSU load path (master 1).
- Round-robin grant, one outstanding transaction at a time; grant held from AR issue until R handshake completes.
- Write channels bypass this block and go straight to the slave.

---
 rtl/axi_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master, one-slave AXI-lite read-channel arbiter.
// Master 0 is the IFU and master 1 is the LSU load path. The block arbitrates
// round-robin and keeps a single transaction in flight, holding the grant from
// AR issue until the R handshake. Write channels do not pass through here.
module axi_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU (master 0)
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  // LSU (master 1)
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  // Shared slave
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;

  logic                  gnt_arvalid;
  logic [ADDR_WIDTH-1:0] gnt_araddr;
  logic                  gnt_rready;

  // State, grant owner and last completed owner; last starts at 1 so the IFU wins first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Select the request and response-ready signals of the current grantee
  always_comb begin
    gnt_arvalid = m0_arvalid;
    gnt_araddr  = m0_araddr;
    gnt_rready  = m0_rready;
    if (grant_q) begin
      gnt_arvalid = m1_arvalid;
      gnt_araddr  = m1_araddr;
      gnt_rready  = m1_rready;
    end
  end

  // Next-state logic: pick a grantee in IDLE, wait for the AR handshake, then the R handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_arvalid && m1_arvalid) begin
          grant_d = ~last_q;
          state_d = ADDR;
        end else if (m0_arvalid) begin
          grant_d = 1'b0;
          state_d = ADDR;
        end else if (m1_arvalid) begin
          grant_d = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!gnt_arvalid) begin
          state_d = IDLE;
        end else if (s_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (s_rvalid && gnt_rready) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output routing from registered state/grant; everything idles at zero outside the active phase
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = 2'b00;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    case (state_q)
      ADDR: begin
        s_arvalid = gnt_arvalid;
        s_araddr  = gnt_araddr;
        if (grant_q) begin
          m1_arready = s_arready;
        end else begin
          m0_arready = s_arready;
        end
      end
      DATA: begin
        s_rready = gnt_rready;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed vectors plus hand-written multi-cycle sequences
// for the two-master AXI-lite read arbiter.
module tb_axi_rd_arbiter;

  typedef struct {
    logic        rst;
    logic        m0_arvalid;
    logic [31:0] m0_araddr;
    logic        m0_rready;
    logic        m1_arvalid;
    logic [31:0] m1_araddr;
    logic        m1_rready;
    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
  } in_t;

  typedef struct {
    logic        m0_arready;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arready;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic        s_rready;
  } exp_t;

  typedef struct {
    string name;
    in_t   ins;
    exp_t  exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  axi_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_arvalid (m0_arvalid),
    .m0_araddr  (m0_araddr),
    .m0_arready (m0_arready),
    .m0_rvalid  (m0_rvalid),
    .m0_rready  (m0_rready),
    .m0_rdata   (m0_rdata),
    .m0_rresp   (m0_rresp),
    .m1_arvalid (m1_arvalid),
    .m1_araddr  (m1_araddr),
    .m1_arready (m1_arready),
    .m1_rvalid  (m1_rvalid),
    .m1_rready  (m1_rready),
    .m1_rdata   (m1_rdata),
    .m1_rresp   (m1_rresp),
    .s_arvalid  (s_arvalid),
    .s_araddr   (s_araddr),
    .s_arready  (s_arready),
    .s_rvalid   (s_rvalid),
    .s_rready   (s_rready),
    .s_rdata    (s_rdata),
    .s_rresp    (s_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a sequence never returns
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t quiet();
    in_t v;
    v.rst = 1'b0; v.m0_arvalid = 1'b0; v.m0_araddr = '0; v.m0_rready = 1'b0;
    v.m1_arvalid = 1'b0; v.m1_araddr = '0; v.m1_rready = 1'b0;
    v.s_arready = 1'b0; v.s_rvalid = 1'b0; v.s_rdata = '0; v.s_rresp = 2'b00;
    return v;
  endfunction

  function automatic in_t mkIn(logic m0v, logic [31:0] m0a, logic m0r,
                               logic m1v, logic [31:0] m1a, logic m1r,
                               logic sar, logic srv, logic [31:0] sd, logic [1:0] srs);
    in_t v;
    v.rst = 1'b0; v.m0_arvalid = m0v; v.m0_araddr = m0a; v.m0_rready = m0r;
    v.m1_arvalid = m1v; v.m1_araddr = m1a; v.m1_rready = m1r;
    v.s_arready = sar; v.s_rvalid = srv; v.s_rdata = sd; v.s_rresp = srs;
    return v;
  endfunction

  function automatic exp_t mkExp(logic m0ar, logic m0rv, logic [31:0] m0d, logic [1:0] m0s,
                                 logic m1ar, logic m1rv, logic [31:0] m1d, logic [1:0] m1s,
                                 logic sarv, logic [31:0] sa, logic srr);
    exp_t e;
    e.m0_arready = m0ar; e.m0_rvalid = m0rv; e.m0_rdata = m0d; e.m0_rresp = m0s;
    e.m1_arready = m1ar; e.m1_rvalid = m1rv; e.m1_rdata = m1d; e.m1_rresp = m1s;
    e.s_arvalid = sarv; e.s_araddr = sa; e.s_rready = srr;
    return e;
  endfunction

  function automatic exp_t allZero();
    return mkExp(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 32'h0, 0);
  endfunction

  task automatic addVec(input string n, input in_t i, input exp_t e);
    vec_t v;
    v.name = n; v.ins = i; v.exp = e;
    vecs.push_back(v);
  endtask

  // One cycle: wait for the active edge, then drive the inputs just after it
  task automatic applyStimulus(input in_t v);
    @(posedge clk);
    #1;
    rst        = v.rst;
    m0_arvalid = v.m0_arvalid;
    m0_araddr  = v.m0_araddr;
    m0_rready  = v.m0_rready;
    m1_arvalid = v.m1_arvalid;
    m1_araddr  = v.m1_araddr;
    m1_rready  = v.m1_rready;
    s_arready  = v.s_arready;
    s_rvalid   = v.s_rvalid;
    s_rdata    = v.s_rdata;
    s_rresp    = v.s_rresp;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    chk({tag, ".m0_arready"}, 32'(m0_arready), 32'(e.m0_arready));
    chk({tag, ".m0_rvalid"},  32'(m0_rvalid),  32'(e.m0_rvalid));
    chk({tag, ".m0_rdata"},   m0_rdata,        e.m0_rdata);
    chk({tag, ".m0_rresp"},   32'(m0_rresp),   32'(e.m0_rresp));
    chk({tag, ".m1_arready"}, 32'(m1_arready), 32'(e.m1_arready));
    chk({tag, ".m1_rvalid"},  32'(m1_rvalid),  32'(e.m1_rvalid));
    chk({tag, ".m1_rdata"},   m1_rdata,        e.m1_rdata);
    chk({tag, ".m1_rresp"},   32'(m1_rresp),   32'(e.m1_rresp));
    chk({tag, ".s_arvalid"},  32'(s_arvalid),  32'(e.s_arvalid));
    chk({tag, ".s_araddr"},   s_araddr,        e.s_araddr);
    chk({tag, ".s_rready"},   32'(s_rready),   32'(e.s_rready));
  endtask

  initial begin
    in_t  cur;
    logic expGrant;
    int   grants;
    bit   done;

    // Directed vector table: each entry is one clock cycle
    addVec("ifu_idle",   mkIn(1, 32'h8000_0000, 0, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00), allZero());
    addVec("ifu_addr",   mkIn(1, 32'h8000_0000, 0, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00),
           mkExp(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 1, 32'h8000_0000, 0));
    addVec("ifu_wait1",  mkIn(0, 32'h8000_0000, 1, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00),
           mkExp(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 32'h0, 1));
    addVec("ifu_wait2",  mkIn(0, 32'h8000_0000, 1, 0, 32'h0, 0, 0, 0, 32'h0, 2'b00),
           mkExp(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 32'h0, 1));
    addVec("ifu_data",   mkIn(0, 32'h8000_0000, 1, 0, 32'h0, 0, 0, 1, 32'h0000_0413, 2'b00),
           mkExp(0, 1, 32'h0000_0413, 2'b00, 0, 0, 32'h0, 2'b00, 0, 32'h0, 1));
    addVec("bubble_stray", mkIn(0, 32'h0, 1, 0, 32'h0, 1, 1, 1, 32'h0000_0055, 2'b01), allZero());
    addVec("lsu_req",    mkIn(0, 32'h0, 0, 1, 32'h8000_2000, 0, 0, 0, 32'h0, 2'b00), allZero());
    addVec("lsu_stall",  mkIn(0, 32'h0, 0, 1, 32'h8000_2000, 0, 0, 0, 32'h0, 2'b00),
           mkExp(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 1, 32'h8000_2000, 0));
    addVec("lsu_withdraw", mkIn(0, 32'h0, 0, 0, 32'h8000_2000, 0, 0, 0, 32'h0, 2'b00),
           mkExp(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 0, 32'h8000_2000, 0));
    addVec("both_idle",  mkIn(1, 32'h8000_3000, 0, 1, 32'h8000_4000, 0, 1, 0, 32'h0, 2'b00), allZero());
    addVec("both_addr_m1", mkIn(1, 32'h8000_3000, 0, 1, 32'h8000_4000, 0, 1, 0, 32'h0, 2'b00),
           mkExp(0, 0, 32'h0, 2'b00, 1, 0, 32'h0, 2'b00, 1, 32'h8000_4000, 0));
    addVec("lsu_err",    mkIn(1, 32'h8000_3000, 0, 0, 32'h8000_4000, 1, 1, 1, 32'hCAFE_F00D, 2'b10),
           mkExp(0, 0, 32'h0, 2'b00, 0, 1, 32'hCAFE_F00D, 2'b10, 0, 32'h0, 1));
    addVec("ifu_pend_idle", mkIn(1, 32'h8000_3000, 0, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00), allZero());
    addVec("ifu_pend_addr", mkIn(1, 32'h8000_3000, 0, 0, 32'h0, 0, 1, 0, 32'h0, 2'b00),
           mkExp(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 2'b00, 1, 32'h8000_3000, 0));
    addVec("ifu_done",   mkIn(0, 32'h0, 1, 0, 32'h0, 0, 0, 1, 32'h1111_2222, 2'b00),
           mkExp(0, 1, 32'h1111_2222, 2'b00, 0, 0, 32'h0, 2'b00, 0, 32'h0, 1));
    addVec("quiet",      quiet(), allZero());

    // Reset and confirm all outputs idle
    cur = quiet();
    cur.rst = 1'b1;
    applyStimulus(cur);
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("reset", allZero());

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ins);
      @(negedge clk);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Slave stalls AR for five cycles; request must stay stable
    cur = quiet();
    cur.m0_arvalid = 1'b1;
    cur.m0_araddr  = 32'h8000_0008;
    applyStimulus(cur);
    @(negedge clk);
    chk("stall_idle.s_arvalid", 32'(s_arvalid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(cur);
      @(negedge clk);
      chk("stall.s_arvalid", 32'(s_arvalid), 32'd1);
      chk("stall.s_araddr", s_araddr, 32'h8000_0008);
      chk("stall.m0_arready", 32'(m0_arready), 32'd0);
    end
    cur.s_arready = 1'b1;
    applyStimulus(cur);
    @(negedge clk);
    chk("stall_hs.m0_arready", 32'(m0_arready), 32'd1);
    chk("stall_hs.s_araddr", s_araddr, 32'h8000_0008);
    cur = quiet();
    cur.m0_rready = 1'b1;
    applyStimulus(cur);
    @(negedge clk);
    chk("stall_data.s_rready", 32'(s_rready), 32'd1);
    chk("stall_data.m0_arready", 32'(m0_arready), 32'd0);
    cur.s_rvalid = 1'b1;
    cur.s_rdata  = 32'h0000_0077;
    applyStimulus(cur);
    @(negedge clk);
    chk("stall_done.m0_rdata", m0_rdata, 32'h0000_0077);

    // LSU holds off rready for four cycles while slave data waits
    cur = quiet();
    cur.m1_arvalid = 1'b1;
    cur.m1_araddr  = 32'h8000_1000;
    cur.s_arready  = 1'b1;
    applyStimulus(cur);
    applyStimulus(cur);
    @(negedge clk);
    chk("bp_addr.m1_arready", 32'(m1_arready), 32'd1);
    cur = quiet();
    cur.s_rvalid = 1'b1;
    cur.s_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(cur);
      @(negedge clk);
      chk("bp_hold.s_rready", 32'(s_rready), 32'd0);
      chk("bp_hold.m1_rvalid", 32'(m1_rvalid), 32'd1);
      chk("bp_hold.m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    end
    cur.m1_rready = 1'b1;
    applyStimulus(cur);
    @(negedge clk);
    chk("bp_release.s_rready", 32'(s_rready), 32'd1);
    applyStimulus(cur);
    @(negedge clk);
    chk("bp_idle.s_rready", 32'(s_rready), 32'd0);
    chk("bp_idle.m1_rvalid", 32'(m1_rvalid), 32'd0);

    // Continuous requests from both masters: grants must alternate starting with the IFU
    cur = quiet();
    cur.m0_arvalid = 1'b1; cur.m0_araddr = 32'h8000_0100; cur.m0_rready = 1'b1;
    cur.m1_arvalid = 1'b1; cur.m1_araddr = 32'h8000_0200; cur.m1_rready = 1'b1;
    cur.s_arready  = 1'b1; cur.s_rvalid  = 1'b1; cur.s_rdata = 32'h0000_ABCD;
    expGrant = 1'b0;
    grants   = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      applyStimulus(cur);
      @(negedge clk);
      if (m0_arready || m1_arready) begin
        chk("fair.single_grant", 32'(m0_arready && m1_arready), 32'd0);
        chk("fair.grant", 32'(m1_arready), 32'(expGrant));
        expGrant = ~expGrant;
        grants++;
        if (grants == 8) done = 1'b1;
      end
    end
    chk("fair.count", 32'(grants), 32'd8);
    cur = quiet();
    cur.m0_rready = 1'b1; cur.m1_rready = 1'b1; cur.s_rvalid = 1'b1;
    applyStimulus(cur);
    applyStimulus(quiet());

    // Reset in DATA: finish an IFU read first so only reset can restore last=1
    cur = quiet();
    cur.m0_arvalid = 1'b1; cur.m0_araddr = 32'h8000_0010; cur.s_arready = 1'b1;
    applyStimulus(cur);
    applyStimulus(cur);
    cur = quiet();
    cur.m0_rready = 1'b1; cur.s_rvalid = 1'b1;
    applyStimulus(cur);
    cur = quiet();
    cur.m1_arvalid = 1'b1; cur.m1_araddr = 32'h8000_5000; cur.s_arready = 1'b1;
    applyStimulus(cur);
    applyStimulus(cur);
    cur = quiet();
    cur.m1_rready = 1'b1;
    applyStimulus(cur);
    @(negedge clk);
    chk("rst_pre.s_rready", 32'(s_rready), 32'd1);
    cur.rst = 1'b1;
    applyStimulus(cur);
    cur = quiet();
    cur.m0_arvalid = 1'b1; cur.m0_araddr = 32'h8000_0004; cur.m0_rready = 1'b1;
    cur.m1_arvalid = 1'b1; cur.m1_araddr = 32'h8000_1000; cur.m1_rready = 1'b1;
    cur.s_arready  = 1'b1; cur.s_rvalid  = 1'b1; cur.s_rdata = 32'h0000_0BAD;
    applyStimulus(cur);
    @(negedge clk);
    checkOutput("post_reset", allZero());
    applyStimulus(cur);
    @(negedge clk);
    chk("post_reset_grant.m0_arready", 32'(m0_arready), 32'd1);
    chk("post_reset_grant.m1_arready", 32'(m1_arready), 32'd0);
    chk("post_reset_grant.s_araddr", s_araddr, 32'h8000_0004);
    applyStimulus(cur);
    @(negedge clk);
    chk("post_reset_data.m0_rvalid", 32'(m0_rvalid), 32'd1);
    applyStimulus(cur);
    applyStimulus(cur);
    @(negedge clk);
    chk("post_reset_next.m1_arready", 32'(m1_arready), 32'd1);
    chk("post_reset_next.s_araddr", s_araddr, 32'h8000_1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
